// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing FSM for the 5-stage LEGv8 pipe: timed init reset, load-use
// bubble, taken-branch flush in MEM, external freeze; with event counters.
//
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   ifid_rn/rm/uses_rm  : source regs of the instruction in IFID
//   idex_memread/rd     : load in IDEX and its destination
//   exmem_branch_taken  : branch resolved taken in MEM
//   ext_halt            : level freeze request
//   pc_write/pc_reset   : PC load enable / clear
//   *_reset / *_stall   : per-stage clear / hold
//   ctrl_bubble         : zero control bits into IDEX
//   state               : INIT=0 RUN=1 HALT=2
//   stall_cnt/flush_cnt : saturating event counters
module pipeline_hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int INIT_CYCLES = 4,
   parameter int XZR         = 31,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rn,
   input  logic [REG_W-1:0] ifid_rm,
   input  logic             ifid_uses_rm,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             exmem_branch_taken,
   input  logic             ext_halt,
   output logic             pc_write,
   output logic             pc_reset,
   output logic             ifid_reset,
   output logic             idex_reset,
   output logic             exmem_reset,
   output logic             memwb_reset,
   output logic             ifid_stall,
   output logic             idex_stall,
   output logic             exmem_stall,
   output logic             memwb_stall,
   output logic             ctrl_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int INIT_N = (INIT_CYCLES < 1) ? 1 : INIT_CYCLES;
   localparam logic [15:0] INIT_LD = 16'(INIT_N - 1);
   localparam logic [REG_W-1:0] ZR = REG_W'(XZR);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_BAD  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [15:0]      r_icnt;
   logic [CNT_W-1:0] r_scnt;
   logic [CNT_W-1:0] r_fcnt;

   logic w_live;
   logic w_go;
   logic w_hazard;
   logic w_do_flush;
   logic w_do_stall;

   assign w_hazard = idex_memread && (idex_rd != ZR) &&
                     ((idex_rd == ifid_rn) ||
                      (ifid_uses_rm && (idex_rd == ifid_rm)));

   // HALT with ext_halt low behaves as RUN, so pending work is
   // acted on in the very cycle the freeze request drops.
   assign w_live     = (r_state == S_RUN) || (r_state == S_HALT);
   assign w_go       = w_live && !ext_halt;
   assign w_do_flush = w_go && exmem_branch_taken;
   assign w_do_stall = w_go && !exmem_branch_taken && w_hazard;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:  if (r_icnt == 16'd0) w_next = S_RUN;
         S_RUN:   if (ext_halt) w_next = S_HALT;
         S_HALT:  if (!ext_halt) w_next = S_RUN;
         default: w_next = S_INIT;
      endcase
   end

   always_comb begin
      pc_write    = 1'b0;
      pc_reset    = 1'b0;
      ifid_reset  = 1'b0;
      idex_reset  = 1'b0;
      exmem_reset = 1'b0;
      memwb_reset = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      memwb_stall = 1'b0;
      ctrl_bubble = 1'b0;
      if (!w_live) begin
         pc_reset    = 1'b1;
         ifid_reset  = 1'b1;
         idex_reset  = 1'b1;
         exmem_reset = 1'b1;
         memwb_reset = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_stall = 1'b1;
      end else if (ext_halt) begin
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_stall = 1'b1;
      end else if (exmem_branch_taken) begin
         pc_write    = 1'b1;
         ifid_reset  = 1'b1;
         idex_reset  = 1'b1;
         exmem_reset = 1'b1;
      end else if (w_hazard) begin
         ifid_stall  = 1'b1;
         ctrl_bubble = 1'b1;
      end else begin
         pc_write    = 1'b1;
      end
   end

   // Init countdown; reloaded whenever the FSM is outside INIT so the
   // recovery path from the unused encoding gets a full init period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_icnt <= INIT_LD;
      end else if (r_state == S_INIT) begin
         if (r_icnt != 16'd0) r_icnt <= r_icnt - 16'd1;
      end else begin
         r_icnt <= INIT_LD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scnt <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_do_stall && (r_scnt != '1)) r_scnt <= r_scnt + 1'b1;
         if (w_do_flush && (r_fcnt != '1)) r_fcnt <= r_fcnt + 1'b1;
      end
   end

   assign state     = r_state;
   assign stall_cnt = r_scnt;
   assign flush_cnt = r_fcnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: default instance plus a
// CNT_W=2 instance on the same stimulus for counter saturation.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ifid_rn = '0;
   logic [4:0] ifid_rm = '0;
   logic       ifid_uses_rm = 1'b0;
   logic       idex_memread = 1'b0;
   logic [4:0] idex_rd = '0;
   logic       exmem_branch_taken = 1'b0;
   logic       ext_halt = 1'b0;

   logic        pc_write, pc_reset;
   logic        ifid_reset, idex_reset, exmem_reset, memwb_reset;
   logic        ifid_stall, idex_stall, exmem_stall, memwb_stall;
   logic        ctrl_bubble;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        d2_pcw, d2_pcr;
   logic        d2_r0, d2_r1, d2_r2, d2_r3;
   logic        d2_s0, d2_s1, d2_s2, d2_s3;
   logic        d2_bub;
   logic [1:0]  d2_state;
   logic [1:0]  d2_scnt, d2_fcnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
      .ifid_uses_rm(ifid_uses_rm),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .exmem_branch_taken(exmem_branch_taken),
      .ext_halt(ext_halt),
      .pc_write(pc_write), .pc_reset(pc_reset),
      .ifid_reset(ifid_reset), .idex_reset(idex_reset),
      .exmem_reset(exmem_reset), .memwb_reset(memwb_reset),
      .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
      .ctrl_bubble(ctrl_bubble), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset),
      .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
      .ifid_uses_rm(ifid_uses_rm),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .exmem_branch_taken(exmem_branch_taken),
      .ext_halt(ext_halt),
      .pc_write(d2_pcw), .pc_reset(d2_pcr),
      .ifid_reset(d2_r0), .idex_reset(d2_r1),
      .exmem_reset(d2_r2), .memwb_reset(d2_r3),
      .ifid_stall(d2_s0), .idex_stall(d2_s1),
      .exmem_stall(d2_s2), .memwb_stall(d2_s3),
      .ctrl_bubble(d2_bub), .state(d2_state),
      .stall_cnt(d2_scnt), .flush_cnt(d2_fcnt)
   );

   typedef struct {
      logic [1:0]  st;
      logic        pcw;
      logic        pcr;
      logic [3:0]  rst;
      logic [3:0]  stl;
      logic        bub;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [1:0]  sc2;
   } exp_t;

   exp_t q[$];

   int n_chk = 0;
   int n_fail = 0;
   int init_seen = 0;

   // model state
   int m_state;
   int m_icnt;
   int m_sc;
   int m_fc;
   int m_sc2;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && state == 2'd0) init_seen++;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("state", 32'(state), 32'(e.st));
         chk("pc_write", 32'(pc_write), 32'(e.pcw));
         chk("pc_reset", 32'(pc_reset), 32'(e.pcr));
         chk("resets", 32'({ifid_reset, idex_reset,
                            exmem_reset, memwb_reset}), 32'(e.rst));
         chk("stalls", 32'({ifid_stall, idex_stall,
                            exmem_stall, memwb_stall}), 32'(e.stl));
         chk("bubble", 32'(ctrl_bubble), 32'(e.bub));
         chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
         chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
         chk("stall_cnt_w2", 32'(d2_scnt), 32'(e.sc2));
      end
   end

   task automatic model_reset();
      m_state = 0;
      m_icnt = 3;
      m_sc = 0;
      m_fc = 0;
      m_sc2 = 0;
   endtask

   // Drive one cycle at posedge+1, push the expected outputs for it,
   // advance the model to the state after the coming edge.
   task automatic drive(input logic mr, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm,
                        input logic urm, input logic br, input logic hlt);
      exp_t e;
      logic haz;
      idex_memread = mr;
      idex_rd = rd;
      ifid_rn = rn;
      ifid_rm = rm;
      ifid_uses_rm = urm;
      exmem_branch_taken = br;
      ext_halt = hlt;
      haz = mr && (rd != 5'd31) && ((rd == rn) || (urm && rd == rm));
      e.st = 2'(m_state);
      e.pcw = 1'b0;
      e.pcr = 1'b0;
      e.rst = 4'h0;
      e.stl = 4'h0;
      e.bub = 1'b0;
      e.sc = 16'(m_sc);
      e.fc = 16'(m_fc);
      e.sc2 = 2'(m_sc2);
      if (m_state == 0) begin
         e.pcr = 1'b1;
         e.rst = 4'hf;
         e.stl = 4'hf;
         if (m_icnt == 0) m_state = 1;
         else m_icnt--;
      end else if (hlt) begin
         e.stl = 4'hf;
         m_state = 2;
      end else begin
         m_state = 1;
         if (br) begin
            e.pcw = 1'b1;
            e.rst = 4'b1110;
            if (m_fc < 65535) m_fc++;
         end else if (haz) begin
            e.stl = 4'b1000;
            e.bub = 1'b1;
            if (m_sc < 65535) m_sc++;
            if (m_sc2 < 3) m_sc2++;
         end else begin
            e.pcw = 1'b1;
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic release_reset();
      idex_memread = 1'b0;
      exmem_branch_taken = 1'b0;
      ext_halt = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      init_seen = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pc_reset", 32'(pc_reset), 32'd1);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      release_reset();

      idle(4);
      chk("init_len", 32'(init_seen), 32'd4);
      idle(1);
      chk("init_len_after", 32'(init_seen), 32'd4);

      // LDUR X2 / ADD rn=2: one bubble
      drive(1, 5'd2, 5'd2, 5'd9, 1, 0, 0);
      idle(1);
      chk("ld_use_cnt", 32'(stall_cnt), 32'd1);
      // XZR destination never hazards
      drive(1, 5'd31, 5'd31, 5'd31, 1, 0, 0);
      // rm hazard only counts when register 2 is read
      drive(1, 5'd5, 5'd7, 5'd5, 1, 0, 0);
      drive(1, 5'd5, 5'd7, 5'd5, 0, 0, 0);
      // memread low: no hazard
      drive(0, 5'd3, 5'd3, 5'd3, 1, 0, 0);
      idle(1);

      // flush beats a coincident hazard
      drive(1, 5'd4, 5'd4, 5'd0, 0, 1, 0);
      idle(1);
      chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
      chk("stall_cnt_keep", 32'(stall_cnt), 32'd2);

      // freeze with a pending hazard, then act on it when released
      for (int i = 0; i < 3; i++) drive(1, 5'd6, 5'd6, 5'd0, 0, 0, 1);
      chk("halt_state", 32'(state), 32'd2);
      drive(1, 5'd6, 5'd6, 5'd0, 0, 0, 0);
      idle(2);
      chk("halt_stall_cnt", 32'(stall_cnt), 32'd3);

      // async reset in the middle of a flush
      exmem_branch_taken = 1'b1;
      #1;
      chk("mid_flush_ifid_reset", 32'(ifid_reset), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_pc_reset", 32'(pc_reset), 32'd1);
      chk("async_pc_write", 32'(pc_write), 32'd0);
      chk("async_stalls", 32'({ifid_stall, idex_stall,
                               exmem_stall, memwb_stall}), 32'hf);
      chk("async_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async_flush_cnt", 32'(flush_cnt), 32'd0);
      release_reset();
      idle(5);

      // five back-to-back hazards: narrow counter sticks at 3
      for (int i = 0; i < 5; i++) drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
      idle(1);
      chk("sat_w2", 32'(d2_scnt), 32'd3);
      chk("sat_w16", 32'(stall_cnt), 32'd5);

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
